// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-item vending controller with serial change return.
// Per-item stock counters are built only when VEND_STOCK_EN is defined.
module vend_ctrl #(
  parameter int PRICE      = 5,
  parameter int NUM_ITEMS  = 4,
  parameter int MAX_CREDIT = 20,
  parameter int CREDIT_W   = 5,
  parameter int STOCK_INIT = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         coin_half,
  input  logic                         coin_one,
  input  logic                         sel_valid,
  input  logic [$clog2(NUM_ITEMS)-1:0] sel_id,
  input  logic                         cancel,
  input  logic                         restock,
  output logic                         drink,
  output logic [$clog2(NUM_ITEMS)-1:0] drink_id,
  output logic                         change,
  output logic                         coin_reject,
  output logic                         sel_error,
  output logic [CREDIT_W-1:0]          credit,
  output logic                         busy,
  output logic [NUM_ITEMS-1:0]         sold_out
);

  localparam int IW = $clog2(NUM_ITEMS);
  localparam int SW = $clog2(STOCK_INIT + 1);
  localparam logic [CREDIT_W+1:0] L_MAX   = (CREDIT_W+2)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] L_ONE   = CREDIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VEND,
    S_CHANGE
  } state_t;

  state_t              r_state;
  state_t              w_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit;
  logic [CREDIT_W-1:0] w_eff;
  logic [CREDIT_W+1:0] w_sum;
  logic [IW-1:0]       r_id;
  logic [IW-1:0]       w_id;
  logic                r_drink;
  logic                w_drink;
  logic                r_change;
  logic                w_change;
  logic                r_rej;
  logic                w_rej;
  logic                r_serr;
  logic                w_serr;
  logic                r_busy;
  logic                w_accept;
  logic                w_coin;
  logic                w_coin_ok;
  logic                w_in_stock;
  logic                w_sel_ok;
  logic [NUM_ITEMS-1:0] w_hit;

  assign w_coin    = coin_half | coin_one;
  assign w_sum     = {2'b00, r_credit}
                   + {{CREDIT_W{1'b0}}, coin_one, coin_half};
  assign w_coin_ok = (w_sum <= L_MAX);
  assign w_eff     = w_coin_ok ? w_sum[CREDIT_W-1:0] : r_credit;

  // one-hot decode; an out-of-range id matches nothing
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_ITEMS; i++)
      w_hit[i] = (sel_id == IW'(i));
  end

  assign w_sel_ok = (|w_hit) & w_in_stock & (w_eff >= L_PRICE);

`ifdef VEND_STOCK_EN
  localparam logic [SW-1:0] L_SINIT = SW'(STOCK_INIT);
  localparam logic [SW-1:0] L_SONE  = SW'(1);

  logic [SW-1:0]        r_stock [NUM_ITEMS];
  logic [SW-1:0]        w_stock [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] r_sold;
  logic [NUM_ITEMS-1:0] w_sold;

  assign w_in_stock = |(w_hit & ~r_sold);

  // restock first, so a same-cycle vend leaves STOCK_INIT-1
  always_comb begin
    w_sold = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      w_stock[i] = restock ? L_SINIT : r_stock[i];
      if (w_accept && w_hit[i])
        w_stock[i] = w_stock[i] - L_SONE;
      w_sold[i] = (w_stock[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ITEMS; i++)
        r_stock[i] <= L_SINIT;
      r_sold <= '0;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++)
        r_stock[i] <= w_stock[i];
      r_sold <= w_sold;
    end
  end

  assign sold_out = r_sold;
`else
  logic w_unused;

  assign w_unused   = restock;
  assign w_in_stock = 1'b1;
  assign sold_out   = '0;
`endif

  always_comb begin
    w_state  = r_state;
    w_credit = r_credit;
    w_id     = r_id;
    w_drink  = 1'b0;
    w_change = 1'b0;
    w_rej    = 1'b0;
    w_serr   = 1'b0;
    w_accept = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_rej    = w_coin & ~w_coin_ok;
        w_credit = w_eff;
        if (cancel) begin
          if (w_eff != '0) begin
            w_state  = S_CHANGE;
            w_change = 1'b1;
            w_credit = w_eff - L_ONE;
          end
        end else if (sel_valid) begin
          if (w_sel_ok) begin
            w_accept = 1'b1;
            w_id     = sel_id;
            w_drink  = 1'b1;
            w_credit = w_eff - L_PRICE;
            w_state  = S_VEND;
          end else begin
            w_serr = 1'b1;
          end
        end
      end
      S_VEND, S_CHANGE: begin
        w_rej = w_coin;
        if (r_credit != '0) begin
          w_state  = S_CHANGE;
          w_change = 1'b1;
          w_credit = r_credit - L_ONE;
        end else begin
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_id     <= '0;
      r_drink  <= 1'b0;
      r_change <= 1'b0;
      r_rej    <= 1'b0;
      r_serr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_credit <= w_credit;
      r_id     <= w_id;
      r_drink  <= w_drink;
      r_change <= w_change;
      r_rej    <= w_rej;
      r_serr   <= w_serr;
      r_busy   <= (w_state != S_IDLE);
    end
  end

  assign drink       = r_drink;
  assign drink_id    = r_id;
  assign change      = r_change;
  assign coin_reject = r_rej;
  assign sel_error   = r_serr;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: random stimulus against a schedule-based model,
// plus directed scenarios with literal expectations.
module tb_vend_ctrl;

  localparam int PRICE = 5;
  localparam int NI    = 4;
  localparam int MAXC  = 20;
  localparam int CW    = 5;
  localparam int SI    = 3;
  localparam int NC    = 8192;
`ifdef VEND_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          coin_half = 1'b0;
  logic          coin_one = 1'b0;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel_id = '0;
  logic          cancel = 1'b0;
  logic          restock = 1'b0;
  logic          drink;
  logic [1:0]    drink_id;
  logic          change;
  logic          coin_reject;
  logic          sel_error;
  logic [CW-1:0] credit;
  logic          busy;
  logic [NI-1:0] sold_out;

  always #5 clk = ~clk;

  vend_ctrl #(
    .PRICE(PRICE), .NUM_ITEMS(NI), .MAX_CREDIT(MAXC),
    .CREDIT_W(CW), .STOCK_INIT(SI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_half(coin_half), .coin_one(coin_one),
    .sel_valid(sel_valid), .sel_id(sel_id),
    .cancel(cancel), .restock(restock),
    .drink(drink), .drink_id(drink_id),
    .change(change), .coin_reject(coin_reject),
    .sel_error(sel_error), .credit(credit),
    .busy(busy), .sold_out(sold_out)
  );

  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", nm, $time, act, exp);
    end
  endtask

  // Expected outputs per cycle; a transaction writes its whole
  // future timeline (drink, change pulses, credit countdown) at once.
  bit e_drink [NC];
  int e_id    [NC];
  bit e_chg   [NC];
  bit e_busy  [NC];
  int e_cred  [NC];
  bit e_rej   [NC];
  bit e_serr  [NC];
  int e_sold  [NC];

  int t = 0;
  int busy_last = -1;
  int m_credit = 0;
  int m_stock [NI];
  int add, eff, r, sid, msk;
  bit acc, was_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_last = -1;
      m_credit  = 0;
      for (int i = 0; i < NI; i++) m_stock[i] = SI;
      e_drink[t] = 0; e_chg[t] = 0; e_busy[t] = 0; e_cred[t] = 0;
      e_rej[t] = 0; e_serr[t] = 0; e_sold[t] = 0;
    end else begin
      t = t + 1;
      was_busy = (t - 1 <= busy_last);
      acc = 1'b0;
      sid = int'(sel_id);
      if (t > busy_last) begin
        e_drink[t] = 0; e_chg[t] = 0; e_busy[t] = 0;
        e_cred[t] = m_credit;
      end
      e_rej[t] = 0;
      e_serr[t] = 0;
      add = int'(coin_half) + 2 * int'(coin_one);
      if (was_busy) begin
        e_rej[t] = (add != 0);
      end else begin
        if (m_credit + add > MAXC) begin
          e_rej[t] = 1;
          eff = m_credit;
        end else begin
          eff = m_credit + add;
        end
        m_credit = eff;
        e_cred[t] = eff;
        if (cancel) begin
          if (eff > 0) begin
            for (int k = 0; k < eff; k++) begin
              e_drink[t+k] = 0; e_chg[t+k] = 1; e_busy[t+k] = 1;
              e_cred[t+k] = eff - 1 - k;
            end
            busy_last = t + eff - 1;
            m_credit = 0;
          end
        end else if (sel_valid) begin
          if (sid < NI && (!STOCK_EN || m_stock[sid] > 0)
              && eff >= PRICE) begin
            acc = 1'b1;
            r = eff - PRICE;
            e_drink[t] = 1; e_id[t] = sid; e_chg[t] = 0;
            e_busy[t] = 1; e_cred[t] = r;
            for (int k = 1; k <= r; k++) begin
              e_drink[t+k] = 0; e_chg[t+k] = 1; e_busy[t+k] = 1;
              e_cred[t+k] = r - k;
            end
            busy_last = t + r;
            m_credit = 0;
          end else begin
            e_serr[t] = 1;
          end
        end
      end
      if (STOCK_EN) begin
        if (restock)
          for (int i = 0; i < NI; i++) m_stock[i] = SI;
        if (acc) m_stock[sid] = m_stock[sid] - 1;
      end
      msk = 0;
      for (int i = 0; i < NI; i++)
        if (STOCK_EN && m_stock[i] == 0) msk = msk | (1 << i);
      e_sold[t] = msk;
    end
  end

  always @(negedge clk) begin
    if (armed && rst_n) begin
      chk("drink", 32'(drink), 32'(e_drink[t]));
      chk("change", 32'(change), 32'(e_chg[t]));
      chk("busy", 32'(busy), 32'(e_busy[t]));
      chk("credit", 32'(credit), e_cred[t]);
      chk("coin_reject", 32'(coin_reject), 32'(e_rej[t]));
      chk("sel_error", 32'(sel_error), 32'(e_serr[t]));
      chk("sold_out", 32'(sold_out), e_sold[t]);
      if (e_drink[t]) chk("drink_id", 32'(drink_id), e_id[t]);
    end
  end

  task automatic cyc(input bit h, input bit o, input bit sv,
                     input int id, input bit cn, input bit rs);
    coin_half = h; coin_one = o; sel_valid = sv;
    sel_id = 2'(id); cancel = cn; restock = rs;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic one();
    cyc(0, 1, 0, 0, 0, 0);
  endtask

  task automatic half();
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic sel(input int id);
    cyc(0, 0, 1, id, 0, 0);
  endtask

  task automatic vend5(input int id);
    one(); one(); half(); sel(id); idle();
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b1;
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drink", 32'(drink), 0);
    chk("rst_sold", 32'(sold_out), 0);

    one();  chk("basic_c2", 32'(credit), 2);
    one();  chk("basic_c4", 32'(credit), 4);
    half(); chk("basic_c5", 32'(credit), 5);
    sel(2);
    chk("basic_drink", 32'(drink), 1);
    chk("basic_id", 32'(drink_id), 2);
    chk("basic_c0", 32'(credit), 0);
    idle();
    chk("basic_nochg", 32'(change), 0);
    chk("basic_idle", 32'(busy), 0);

    one(); one(); one();
    chk("over_c6", 32'(credit), 6);
    sel(0);
    chk("over_drink", 32'(drink), 1);
    chk("over_busy1", 32'(busy), 1);
    idle();
    chk("over_chg", 32'(change), 1);
    chk("over_busy2", 32'(busy), 1);
    idle();
    chk("over_chg_end", 32'(change), 0);
    chk("over_busy_end", 32'(busy), 0);

    cyc(1, 1, 0, 0, 0, 0);
    chk("cancel_c3", 32'(credit), 3);
    cyc(0, 0, 1, 0, 1, 0);
    chk("cancel_nodrink", 32'(drink), 0);
    chk("cancel_p1", 32'(change), 1);
    idle(); chk("cancel_p2", 32'(change), 1);
    idle(); chk("cancel_p3", 32'(change), 1);
    chk("cancel_c0", 32'(credit), 0);
    idle(); chk("cancel_done", 32'(change), 0);

    repeat (9) one();
    half();
    chk("sat_c19", 32'(credit), 19);
    one();
    chk("sat_rej", 32'(coin_reject), 1);
    chk("sat_keep", 32'(credit), 19);
    cyc(0, 0, 0, 0, 1, 0);
    half();
    chk("busy_rej", 32'(coin_reject), 1);
    chk("busy_c17", 32'(credit), 17);
    repeat (22) idle();

    vend5(1); vend5(1); vend5(1);
    one(); one(); half();
`ifdef VEND_STOCK_EN
    sel(1);
    chk("so_bit", 32'(sold_out[1]), 1);
    chk("so_err", 32'(sel_error), 1);
    chk("so_c5", 32'(credit), 5);
    cyc(0, 0, 0, 0, 0, 1);
    chk("restock_so", 32'(sold_out), 0);
`else
    sel(1);
    chk("nostock_drink", 32'(drink), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("nostock_so", 32'(sold_out), 0);
    one(); one(); half();
`endif
    sel(1);
    chk("restock_drink", 32'(drink), 1);
    chk("restock_id", 32'(drink_id), 1);
    idle();

    for (int n = 0; n < 2500; n++)
      cyc(($urandom % 100) < 25, ($urandom % 100) < 25,
          ($urandom % 100) < 15, int'($urandom % 4),
          ($urandom % 100) < 3, ($urandom % 100) < 2);

    repeat (25) idle();
    cyc(0, 0, 0, 0, 1, 0);
    repeat (25) idle();

    repeat (5) one();
    chk("rstm_c10", 32'(credit), 10);
    sel(3);
    chk("rstm_drink", 32'(drink), 1);
    idle(); chk("rstm_p1", 32'(change), 1);
    idle(); chk("rstm_p2", 32'(change), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_chg", 32'(change), 0);
    chk("rstm_credit", 32'(credit), 0);
    chk("rstm_busy", 32'(busy), 0);
    chk("rstm_sold", 32'(sold_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    one(); one(); one();
    sel(3);
    chk("post_drink", 32'(drink), 1);
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
